// File: rtl/vector_sweep_ctrl.sv
// vector_sweep_ctrl
//   Walks an AW-bit stimulus vector from 0 up to all-ones. Each vector is
//   held for SETTLE cycles. The response y is then folded into a 32-bit
//   LFSR-style signature during one CAPTURE cycle.
//
// Ports
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : sweep request, only honoured in IDLE (abort has priority)
//   abort  : cancels a running sweep; sig/count freeze at pre-abort values
//   a      : stimulus to the expression under test
//   y      : response from the expression under test, zero-extended
//   busy   : high in SETTLE and CAPTURE (registered state decode)
//   done   : one-cycle pulse when the sweep completes
//   sig    : response signature
//   count  : vectors captured in the current or last sweep
module vector_sweep_ctrl #(
    parameter int AW     = 4,
    parameter int YW     = 8,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] a,
    input  logic [YW-1:0] y,
    output logic          busy,
    output logic          done,
    output logic [31:0]   sig,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

    localparam logic [3:0] STL_LAST = 4'(SETTLE - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [31:0]   sig_q, sig_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [3:0]    stl_q, stl_d;

    logic [31:0]   y_ext;
    logic [31:0]   sig_upd;

    // Unsigned cast: y is always zero-extended into the signature.
    assign y_ext   = 32'(y);
    assign sig_upd = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ y_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            stl_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            stl_q   <= stl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        stl_d   = stl_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    a_d     = '0;
                    sig_d   = '0;
                    cnt_d   = '0;
                    stl_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (stl_q == STL_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    stl_d = stl_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                // Abort wins over the capture: signature and count stay put.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sig_d = sig_upd;
                    cnt_d = cnt_q + 1'b1;
                    if (a_q == '1) begin
                        state_d = S_DONE;
                    end else begin
                        a_d     = a_q + 1'b1;
                        stl_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign a     = a_q;
    assign sig   = sig_q;
    assign count = cnt_q;
    assign busy  = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
module tb_vector_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // A: AW=4, SETTLE=1, y selectable
    logic        st_a, ab_a, busy_a, done_a;
    logic [3:0]  a_a;
    logic [7:0]  y_a;
    logic [31:0] sig_a;
    logic [4:0]  cnt_a;
    int          ymode_a;
    // B: AW=4, SETTLE=3, y = a
    logic        st_b, ab_b, busy_b, done_b;
    logic [3:0]  a_b;
    logic [7:0]  y_b;
    logic [31:0] sig_b;
    logic [4:0]  cnt_b;
    // C: AW=1, SETTLE=1, y = 1
    logic        st_c, ab_c, busy_c, done_c;
    logic [0:0]  a_c;
    logic [7:0]  y_c;
    logic [31:0] sig_c;
    logic [1:0]  cnt_c;

    // mode 1 sets the MSB for low a values, exposing any sign extension
    always_comb y_a = (ymode_a == 1) ? {~a_a, a_a} : 8'h00;
    assign y_b = {4'h0, a_b};
    assign y_c = 8'h01;

    vector_sweep_ctrl #(.AW(4), .YW(8), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .abort(ab_a), .a(a_a), .y(y_a),
        .busy(busy_a), .done(done_a), .sig(sig_a), .count(cnt_a));
    vector_sweep_ctrl #(.AW(4), .YW(8), .SETTLE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .abort(ab_b), .a(a_b), .y(y_b),
        .busy(busy_b), .done(done_b), .sig(sig_b), .count(cnt_b));
    vector_sweep_ctrl #(.AW(1), .YW(8), .SETTLE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st_c), .abort(ab_c), .a(a_c), .y(y_c),
        .busy(busy_c), .done(done_c), .sig(sig_c), .count(cnt_c));

    typedef struct {
        logic [31:0] sig;
        logic [4:0]  cnt;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int ncmp  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference signature after nvec captures with vector v driving y.
    function automatic logic [31:0] model(input int nvec, input int mode);
        logic [31:0] s;
        logic [7:0]  yv;
        s = 32'h0;
        for (int v = 0; v < nvec; v++) begin
            case (mode)
                0:       yv = 8'h00;
                1:       yv = {~4'(v), 4'(v)};
                2:       yv = 8'(v);
                default: yv = 8'h01;
            endcase
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ {24'h0, yv};
        end
        return s;
    endfunction

    // Returns at the negedge of cycle 1 (first cycle after the start edge).
    task automatic start_a();
        @(negedge clk);
        st_a = 1'b1;
        #1 chk("busy_not_comb_from_start", 64'(busy_a), 64'(0));
        @(negedge clk);
        st_a = 1'b0;
    endtask

    task automatic sweep_a(input string tag, input int mode, input bit repulse);
        int cyc;
        ymode_a = mode;
        sb.push_back('{model(16, mode), 5'd16});
        start_a();
        chk({tag, "_busy_c1"}, 64'(busy_a), 64'(1));
        cyc = 1;
        while (!done_a && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (repulse && cyc == 10) st_a = 1'b1;
            if (cyc == 11) st_a = 1'b0;
        end
        e = sb.pop_front();
        chk({tag, "_done"}, 64'(done_a), 64'(1));
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(33));
        chk({tag, "_sig"}, 64'(sig_a), 64'(e.sig));
        chk({tag, "_count"}, 64'(cnt_a), 64'(e.cnt));
        chk({tag, "_a_final"}, 64'(a_a), 64'(4'hF));
        // start and abort during DONE are both ignored
        st_a = 1'b1;
        ab_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        ab_a = 1'b0;
        chk({tag, "_done_one_cycle"}, 64'(done_a), 64'(0));
        @(negedge clk);
        chk({tag, "_idle_after"}, 64'(busy_a), 64'(0));
        repeat (3) @(negedge clk);
        chk({tag, "_sig_stable"}, 64'(sig_a), 64'(e.sig));
        chk({tag, "_count_stable"}, 64'(cnt_a), 64'(e.cnt));
    endtask

    initial begin
        int cyc;
        int bad;
        bit saw;
        logic [31:0] s_keep;

        rst_n = 1'b0;
        st_a = 0; ab_a = 0; st_b = 0; ab_b = 0; st_c = 0; ab_c = 0;
        ymode_a = 0;
        repeat (2) @(negedge clk);
        chk("rst_a", 64'(a_a), 64'(0));
        chk("rst_sig", 64'(sig_a), 64'(0));
        chk("rst_count", 64'(cnt_a), 64'(0));
        chk("rst_busy", 64'(busy_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        rst_n = 1'b1;

        // y tied to zero
        sweep_a("zero", 0, 1'b0);
        // y with MSB set, restart attempt mid-sweep
        sweep_a("pat", 1, 1'b1);

        // abort during the third CAPTURE (cycle 6 with SETTLE=1)
        ymode_a = 1;
        sb.push_back('{model(2, 1), 5'd2});
        start_a();
        repeat (5) @(negedge clk);
        ab_a = 1'b1;
        chk("abort_busy_before", 64'(busy_a), 64'(1));
        @(negedge clk);
        ab_a = 1'b0;
        e = sb.pop_front();
        chk("abort_idle", 64'(busy_a), 64'(0));
        chk("abort_count", 64'(cnt_a), 64'(e.cnt));
        chk("abort_sig", 64'(sig_a), 64'(e.sig));
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_a) saw = 1'b1;
        end
        chk("abort_no_done", 64'(saw), 64'(0));

        // start and abort together in IDLE: no sweep
        st_a = 1'b1;
        ab_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        ab_a = 1'b0;
        @(negedge clk);
        chk("start_abort_idle_busy", 64'(busy_a), 64'(0));
        chk("start_abort_idle_count", 64'(cnt_a), 64'(2));
        chk("start_abort_idle_sig", 64'(sig_a), 64'(e.sig));

        // asynchronous reset in the SETTLE of vector 2 (cycle 5)
        start_a();
        repeat (4) @(negedge clk);
        s_keep = sig_a;
        chk("pre_rst_sig_nonzero", 64'(s_keep != 32'h0), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_a", 64'(a_a), 64'(0));
        chk("async_rst_sig", 64'(sig_a), 64'(0));
        chk("async_rst_count", 64'(cnt_a), 64'(0));
        chk("async_rst_busy", 64'(busy_a), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sweep_a("post_rst", 1, 1'b0);

        // B: y = a, SETTLE=3, each vector held 4 cycles
        sb.push_back('{model(16, 2), 5'd16});
        @(negedge clk);
        st_b = 1'b1;
        @(negedge clk);
        st_b = 1'b0;
        cyc = 1;
        bad = 0;
        while (!done_b && cyc < 400) begin
            if (cyc <= 64 && a_b !== 4'((cyc - 1) / 4)) bad++;
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        chk("b_hold", 64'(bad), 64'(0));
        chk("b_done", 64'(done_b), 64'(1));
        chk("b_done_cycle", 64'(cyc), 64'(65));
        chk("b_sig", 64'(sig_b), 64'(e.sig));
        chk("b_count", 64'(cnt_b), 64'(e.cnt));

        // C: AW=1, y=1 -> sig 2 after two vectors
        sb.push_back('{32'h0000_0002, 5'd2});
        @(negedge clk);
        st_c = 1'b1;
        @(negedge clk);
        st_c = 1'b0;
        chk("c_a0", 64'(a_c), 64'(0));
        cyc = 1;
        while (!done_c && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        chk("c_done", 64'(done_c), 64'(1));
        chk("c_done_cycle", 64'(cyc), 64'(5));
        chk("c_sig", 64'(sig_c), 64'(e.sig));
        chk("c_count", 64'(cnt_c), 64'(e.cnt));
        chk("c_a_final", 64'(a_c), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
